// File: rtl/tlb_request_arbiter.sv
// ============================================================================
// Module   : tlb_request_arbiter
// Purpose  : Shares one TLB lookup port between the code, data-read and
//            data-write requesters, and serialises TLB flushes against lookups.
//            Optional macro TLB_ARB_STARVE_EN adds the code starvation guard.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tlb_request_arbiter #(
  parameter logic [3:0] STARVE_LIMIT = 4'd3
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        code_req_do,
  input  logic [31:0] code_req_address,
  input  logic        code_req_su,
  input  logic        rd_req_do,
  input  logic [31:0] rd_req_address,
  input  logic        rd_req_su,
  input  logic        wr_req_do,
  input  logic [31:0] wr_req_address,
  input  logic        wr_req_su,

  output logic        code_done,
  output logic        rd_done,
  output logic        wr_done,
  output logic [31:0] resp_linear,
  output logic [31:0] resp_physical,
  output logic        resp_cache_disable,

  output logic        tlb_req_do,
  output logic [31:0] tlb_req_address,
  output logic        tlb_req_su,
  output logic        tlb_req_wr,
  output logic        tlb_req_code,
  input  logic        tlb_resp_do,
  input  logic [31:0] tlb_resp_linear,
  input  logic [31:0] tlb_resp_physical,
  input  logic        tlb_resp_cache_disable,

  input  logic        flush_do,
  output logic        flush_done,
  output logic        tlb_flush_do,
  input  logic        tlb_flush_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        su_q, su_d;
  logic        wr_q, wr_d;
  logic        code_q, code_d;
  logic [2:0]  owner_q, owner_d;
  logic        abandon_q, abandon_d;

  // One-hot vectors are ordered {wr, rd, code} throughout.
  logic [2:0]  req_vec;
  logic [2:0]  win;
  logic [2:0]  done_vec;
  logic [31:0] win_addr;
  logic        win_su;
  logic        owner_live;
  logic        lookup_grant;
  logic        promote_code;

  assign req_vec            = {wr_req_do, rd_req_do, code_req_do};
  assign owner_live         = |(owner_q & req_vec);
  assign code_done          = done_vec[0];
  assign rd_done            = done_vec[1];
  assign wr_done            = done_vec[2];
  assign resp_linear        = tlb_resp_linear;
  assign resp_physical      = tlb_resp_physical;
  assign resp_cache_disable = tlb_resp_cache_disable;

`ifdef TLB_ARB_STARVE_EN
  logic [3:0] starve_cnt_q, starve_cnt_d;

  assign promote_code = code_req_do && (starve_cnt_q == STARVE_LIMIT);

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!code_req_do || (lookup_grant && win[0])) begin
      starve_cnt_d = 4'd0;
    end else if (lookup_grant && (starve_cnt_q < STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt_q <= 4'd0;
    else        starve_cnt_q <= starve_cnt_d;
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign promote_code        = 1'b0;
`endif

  always_comb begin
    win = 3'b000;
    if (promote_code)     win = 3'b001;
    else if (wr_req_do)   win = 3'b100;
    else if (rd_req_do)   win = 3'b010;
    else if (code_req_do) win = 3'b001;
  end

  always_comb begin
    win_addr = code_req_address;
    win_su   = code_req_su;
    if (win[2]) begin
      win_addr = wr_req_address;
      win_su   = wr_req_su;
    end else if (win[1]) begin
      win_addr = rd_req_address;
      win_su   = rd_req_su;
    end
  end

  // Outputs are gated by rst_n so the TLB sees requests drop as soon as reset asserts.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    su_d            = su_q;
    wr_d            = wr_q;
    code_d          = code_q;
    owner_d         = owner_q;
    abandon_d       = abandon_q;
    done_vec        = 3'b000;
    lookup_grant    = 1'b0;
    tlb_req_do      = 1'b0;
    tlb_req_address = 32'd0;
    tlb_req_su      = 1'b0;
    tlb_req_wr      = 1'b0;
    tlb_req_code    = 1'b0;
    tlb_flush_do    = 1'b0;
    flush_done      = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_IDLE: begin
          if (flush_do) begin
            tlb_flush_do = 1'b1;
            if (tlb_flush_done) flush_done = 1'b1;
            else                state_d    = ST_FLUSH;
          end else if (|win) begin
            lookup_grant    = 1'b1;
            tlb_req_do      = 1'b1;
            tlb_req_address = win_addr;
            tlb_req_su      = win_su;
            tlb_req_wr      = win[2];
            tlb_req_code    = win[0];
            addr_d          = win_addr;
            su_d            = win_su;
            wr_d            = win[2];
            code_d          = win[0];
            owner_d         = win;
            if (tlb_resp_do) done_vec = win;
            else             state_d  = ST_BUSY;
          end
        end
        ST_BUSY: begin
          tlb_req_do      = 1'b1;
          tlb_req_address = addr_q;
          tlb_req_su      = su_q;
          tlb_req_wr      = wr_q;
          tlb_req_code    = code_q;
          if (!owner_live) abandon_d = 1'b1;
          if (tlb_resp_do) begin
            if (!abandon_q && owner_live) done_vec = owner_q;
            abandon_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
        ST_FLUSH: begin
          tlb_flush_do = 1'b1;
          if (tlb_flush_done) begin
            flush_done = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= 32'd0;
      su_q      <= 1'b0;
      wr_q      <= 1'b0;
      code_q    <= 1'b0;
      owner_q   <= 3'b000;
      abandon_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      su_q      <= su_d;
      wr_q      <= wr_d;
      code_q    <= code_d;
      owner_q   <= owner_d;
      abandon_q <= abandon_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tlb_request_arbiter.sv
// ============================================================================
// Module   : tb_tlb_request_arbiter
// Purpose  : Cycle-table directed test of tlb_request_arbiter plus a
//            hand-written multi-cycle latency sequence.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tlb_request_arbiter;

  localparam logic [31:0] CODE_ADDR = 32'h0040_1234;
  localparam logic [31:0] RD_ADDR   = 32'h0000_8000;
  localparam logic [31:0] WR_ADDR   = 32'h0000_C000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        code_req_do = 1'b0, rd_req_do = 1'b0, wr_req_do = 1'b0;
  logic        flush_do = 1'b0, tlb_resp_do = 1'b0, tlb_flush_done = 1'b0;
  logic [31:0] tlb_resp_linear = 32'd0, tlb_resp_physical = 32'd0;
  logic        tlb_resp_cache_disable = 1'b0;
  logic        code_done, rd_done, wr_done, flush_done;
  logic [31:0] resp_linear, resp_physical, tlb_req_address;
  logic        resp_cache_disable, tlb_req_do, tlb_req_su, tlb_req_wr, tlb_req_code, tlb_flush_do;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tlb_request_arbiter #(.STARVE_LIMIT(4'd3)) dut (
    .clk(clk), .rst_n(rst_n),
    .code_req_do(code_req_do), .code_req_address(CODE_ADDR), .code_req_su(1'b1),
    .rd_req_do(rd_req_do), .rd_req_address(RD_ADDR), .rd_req_su(1'b0),
    .wr_req_do(wr_req_do), .wr_req_address(WR_ADDR), .wr_req_su(1'b1),
    .code_done(code_done), .rd_done(rd_done), .wr_done(wr_done),
    .resp_linear(resp_linear), .resp_physical(resp_physical),
    .resp_cache_disable(resp_cache_disable),
    .tlb_req_do(tlb_req_do), .tlb_req_address(tlb_req_address), .tlb_req_su(tlb_req_su),
    .tlb_req_wr(tlb_req_wr), .tlb_req_code(tlb_req_code),
    .tlb_resp_do(tlb_resp_do), .tlb_resp_linear(tlb_resp_linear),
    .tlb_resp_physical(tlb_resp_physical), .tlb_resp_cache_disable(tlb_resp_cache_disable),
    .flush_do(flush_do), .flush_done(flush_done),
    .tlb_flush_do(tlb_flush_do), .tlb_flush_done(tlb_flush_done)
  );

  // One record per clock cycle; req is {wr, rd, code}, done is {flush, wr, rd, code},
  // kind is {wr, code} of the expected lookup.
  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic       fl;
    logic       resp;
    logic       fd;
    logic [3:0] done;
    logic       ereq;
    logic [1:0] kind;
    logic       efl;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic [2:0] rq, input logic fl, input logic rs,
                     input logic fd, input logic [3:0] dn, input logic er,
                     input logic [1:0] ek, input logic ef);
    vec_t t;
    t.rst = r; t.req = rq; t.fl = fl; t.resp = rs; t.fd = fd;
    t.done = dn; t.ereq = er; t.kind = ek; t.efl = ef;
    tv.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  function automatic logic [32:0] exp_addr_su(input logic [1:0] k);
    if (k == 2'b10)      return {WR_ADDR, 1'b1};
    else if (k == 2'b01) return {CODE_ADDR, 1'b1};
    else                 return {RD_ADDR, 1'b0};
  endfunction

  task automatic hand_latency();
    int  cyc;
    bit  got;
    bit  stable;
    @(posedge clk); #1;
    rd_req_do              = 1'b1;
    tlb_resp_linear        = RD_ADDR;
    tlb_resp_physical      = 32'h0120_1234;
    tlb_resp_cache_disable = 1'b1;
    got = 1'b0; stable = 1'b1; cyc = 0;
    while (!got && cyc < 20) begin
      tlb_resp_do = (cyc == 4);
      @(negedge clk);
      if (tlb_req_do !== 1'b1 || tlb_req_address !== RD_ADDR || tlb_req_wr !== 1'b0) stable = 1'b0;
      if (rd_done === 1'b1) begin
        got = 1'b1;
        chk("resp_passthru", {resp_linear, resp_physical}, {RD_ADDR, 32'h0120_1234});
        chk("resp_cd", {63'd0, resp_cache_disable}, 64'd1);
      end
      @(posedge clk); #1;
      cyc++;
    end
    rd_req_do   = 1'b0;
    tlb_resp_do = 1'b0;
    chk("lat_done_seen", {63'd0, got}, 64'd1);
    chk("lat_cycles", 64'(cyc), 64'd5);
    chk("lat_addr_stable", {63'd0, stable}, 64'd1);
    @(negedge clk);
    chk("lat_idle_after", {62'd0, tlb_req_do, rd_done}, 64'd0);
  endtask

  initial begin
    // Reset with a live code request: everything low.
    add(0, 3'b001, 0, 0, 0, 4'b0000, 0, 2'b00, 0);
    // Code lookup, TLB answers on the third cycle.
    add(1, 3'b001, 0, 0, 0, 4'b0000, 1, 2'b01, 0);
    add(1, 3'b001, 0, 0, 0, 4'b0000, 1, 2'b01, 0);
    add(1, 3'b001, 0, 1, 0, 4'b0001, 1, 2'b01, 0);
    add(1, 3'b000, 0, 0, 0, 4'b0000, 0, 2'b00, 0);
    // rd and code together: rd first, then code.
    add(1, 3'b011, 0, 0, 0, 4'b0000, 1, 2'b00, 0);
    add(1, 3'b011, 0, 1, 0, 4'b0010, 1, 2'b00, 0);
    add(1, 3'b001, 0, 0, 0, 4'b0000, 1, 2'b01, 0);
    add(1, 3'b001, 0, 1, 0, 4'b0001, 1, 2'b01, 0);
    add(1, 3'b000, 0, 0, 0, 4'b0000, 0, 2'b00, 0);
    // Code withdrawn mid-lookup: request held, response discarded.
    add(1, 3'b001, 0, 0, 0, 4'b0000, 1, 2'b01, 0);
    add(1, 3'b000, 0, 0, 0, 4'b0000, 1, 2'b01, 0);
    add(1, 3'b000, 0, 0, 0, 4'b0000, 1, 2'b01, 0);
    add(1, 3'b000, 0, 1, 0, 4'b0000, 1, 2'b01, 0);
    add(1, 3'b000, 0, 0, 0, 4'b0000, 0, 2'b00, 0);
    // Withdrawn then re-raised before the response: still discarded.
    add(1, 3'b001, 0, 0, 0, 4'b0000, 1, 2'b01, 0);
    add(1, 3'b000, 0, 0, 0, 4'b0000, 1, 2'b01, 0);
    add(1, 3'b001, 0, 1, 0, 4'b0000, 1, 2'b01, 0);
    add(1, 3'b001, 0, 0, 0, 4'b0000, 1, 2'b01, 0);
    add(1, 3'b001, 0, 1, 0, 4'b0001, 1, 2'b01, 0);
    add(1, 3'b000, 0, 0, 0, 4'b0000, 0, 2'b00, 0);
    // Owner drops in the same cycle the response arrives.
    add(1, 3'b010, 0, 0, 0, 4'b0000, 1, 2'b00, 0);
    add(1, 3'b000, 0, 1, 0, 4'b0000, 1, 2'b00, 0);
    add(1, 3'b000, 0, 0, 0, 4'b0000, 0, 2'b00, 0);
    // Flush with wr pending; a stray tlb_resp_do during FLUSH is ignored.
    add(1, 3'b100, 1, 0, 0, 4'b0000, 0, 2'b00, 1);
    add(1, 3'b100, 1, 1, 0, 4'b0000, 0, 2'b00, 1);
    add(1, 3'b100, 1, 0, 0, 4'b0000, 0, 2'b00, 1);
    add(1, 3'b100, 1, 0, 1, 4'b1000, 0, 2'b00, 1);
    add(1, 3'b100, 0, 0, 0, 4'b0000, 1, 2'b10, 0);
    add(1, 3'b100, 0, 1, 0, 4'b0100, 1, 2'b10, 0);
    add(1, 3'b000, 0, 0, 0, 4'b0000, 0, 2'b00, 0);
    // Flush raised while BUSY waits; then zero-latency flush.
    add(1, 3'b010, 0, 0, 0, 4'b0000, 1, 2'b00, 0);
    add(1, 3'b010, 1, 0, 0, 4'b0000, 1, 2'b00, 0);
    add(1, 3'b010, 1, 1, 0, 4'b0010, 1, 2'b00, 0);
    add(1, 3'b000, 1, 0, 1, 4'b1000, 0, 2'b00, 1);
    add(1, 3'b000, 0, 0, 0, 4'b0000, 0, 2'b00, 0);
    // Zero-latency lookup, and wr held across two dones.
    add(1, 3'b010, 0, 1, 0, 4'b0010, 1, 2'b00, 0);
    add(1, 3'b000, 0, 0, 0, 4'b0000, 0, 2'b00, 0);
    add(1, 3'b100, 0, 1, 0, 4'b0100, 1, 2'b10, 0);
    add(1, 3'b100, 0, 1, 0, 4'b0100, 1, 2'b10, 0);
    add(1, 3'b000, 0, 0, 0, 4'b0000, 0, 2'b00, 0);
    // Fixed priority wr > rd > code.
    add(1, 3'b111, 0, 1, 0, 4'b0100, 1, 2'b10, 0);
    add(1, 3'b011, 0, 1, 0, 4'b0010, 1, 2'b00, 0);
    add(1, 3'b000, 0, 0, 0, 4'b0000, 0, 2'b00, 0);
    add(1, 3'b001, 0, 1, 0, 4'b0001, 1, 2'b01, 0);
    add(1, 3'b000, 0, 0, 0, 4'b0000, 0, 2'b00, 0);
    // rd held with code waiting.
    add(1, 3'b011, 0, 1, 0, 4'b0010, 1, 2'b00, 0);
    add(1, 3'b011, 0, 1, 0, 4'b0010, 1, 2'b00, 0);
    add(1, 3'b011, 0, 1, 0, 4'b0010, 1, 2'b00, 0);
`ifdef TLB_ARB_STARVE_EN
    add(1, 3'b011, 0, 1, 0, 4'b0001, 1, 2'b01, 0);
`else
    add(1, 3'b011, 0, 1, 0, 4'b0010, 1, 2'b00, 0);
`endif
    add(1, 3'b011, 0, 1, 0, 4'b0010, 1, 2'b00, 0);
    add(1, 3'b000, 0, 0, 0, 4'b0000, 0, 2'b00, 0);
    // Reset mid-BUSY, response after release produces nothing.
    add(1, 3'b001, 0, 0, 0, 4'b0000, 1, 2'b01, 0);
    add(0, 3'b001, 0, 0, 0, 4'b0000, 0, 2'b00, 0);
    add(1, 3'b000, 0, 1, 0, 4'b0000, 0, 2'b00, 0);
    // Reset mid-FLUSH.
    add(1, 3'b000, 1, 0, 0, 4'b0000, 0, 2'b00, 1);
    add(0, 3'b000, 1, 0, 0, 4'b0000, 0, 2'b00, 0);
    add(1, 3'b000, 0, 0, 1, 4'b0000, 0, 2'b00, 0);

    for (int i = 0; i < tv.size(); i++) begin
      @(posedge clk); #1;
      rst_n          = tv[i].rst;
      {wr_req_do, rd_req_do, code_req_do} = tv[i].req;
      flush_do       = tv[i].fl;
      tlb_resp_do    = tv[i].resp;
      tlb_flush_done = tv[i].fd;
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i),
          {56'd0, flush_done, wr_done, rd_done, code_done,
           tlb_req_do, tlb_req_wr, tlb_req_code, tlb_flush_do},
          {56'd0, tv[i].done, tv[i].ereq, tv[i].kind, tv[i].efl});
      if (tv[i].ereq)
        chk($sformatf("vec%0d_addr", i), {31'd0, tlb_req_address, tlb_req_su},
            {31'd0, exp_addr_su(tv[i].kind)});
    end
    tlb_flush_done = 1'b0;

    hand_latency();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
